// File: rtl/input_port_if.sv
// Board-to-CPU input handshake bundle: raw switch/button/read inputs and the captured-word outputs.
interface input_port_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw;
  logic             btn;
  logic             rd;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             overrun;

  modport master (output sw, btn, rd, input data, valid, overrun);
  modport slave  (input sw, btn, rd, output data, valid, overrun);
endinterface

// File: rtl/input_port.sv
// Synchronises switches, button and CPU read; debounces the button and captures the switch word
// on each debounced press, offering it to the CPU through a valid / read-edge handshake.
module input_port #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input_port_if.slave  port
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} state_t;

  logic [SYNC_STAGES-1:0]            btn_sync;
  logic [SYNC_STAGES-1:0]            rd_sync;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sw_sync;
  logic             btn_s;
  logic             rd_s;
  logic [WIDTH-1:0] sw_s;

  logic             rd_prev;
  logic             rd_edge;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             press;

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_sync <= '0;
      rd_sync  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], port.btn};
      rd_sync  <= {rd_sync[SYNC_STAGES-2:0], port.rd};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], port.sw};
    end
  end

  assign btn_s = btn_sync[SYNC_STAGES-1];
  assign rd_s  = rd_sync[SYNC_STAGES-1];
  assign sw_s  = sw_sync[SYNC_STAGES-1];

  // Read edge is registered, so a consume lands two cycles after the synced read rises.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_prev <= 1'b0;
      rd_edge <= 1'b0;
    end else begin
      rd_prev <= rd_s;
      rd_edge <= rd_s & ~rd_prev;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      LOW: begin
        if (btn_s) begin
          state_nx = WAIT_HI;
          cnt_nx   = CW'(1);
        end
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!btn_s) begin
          state_nx = WAIT_LO;
          cnt_nx   = CW'(1);
        end
      end
      WAIT_LO: begin
        if (btn_s) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    press = 1'b0;
    if (state == WAIT_HI && btn_s && cnt == CW'(DEBOUNCE_CYCLES)) press = 1'b1;
  end

  // A read edge coinciding with a press consumes the old word, so no overrun is flagged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (press) begin
      data_q  <= sw_s;
      valid_q <= 1'b1;
      if (rd_edge)      overrun_q <= 1'b0;
      else if (valid_q) overrun_q <= 1'b1;
    end else if (rd_edge && valid_q) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign port.data    = data_q;
  assign port.valid   = valid_q;
  assign port.overrun = overrun_q;
endmodule

// File: tb/tb_input_port.sv
// Bench for input_port: directed scenarios plus randomized traffic against a run-length / unread-count model.
module tb_input_port;
  localparam int W    = 8;
  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  input_port_if #(.WIDTH(W)) bus ();

  input_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .port  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_word;

  // Reference: inputs seen SYNC cycles late; button level flips after DEB+1 consecutive
  // differing cycles; outputs follow a count of words captured since the last read.
  logic [SYNC-1:0]         m_btn;
  logic [SYNC-1:0][W-1:0]  m_sw;
  logic [SYNC+1:0]         m_rd;
  logic                    m_level;
  int                      m_run;
  int                      m_unread;
  logic [W-1:0]            m_data;
  logic                    m_press, m_rd_edge;

  assign m_press   = m_btn[SYNC-1] && !m_level && (m_run == DEB);
  assign m_rd_edge = m_rd[SYNC] && !m_rd[SYNC+1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_btn <= '0; m_sw <= '0; m_rd <= '0;
      m_level <= 1'b0; m_run <= 0; m_unread <= 0; m_data <= '0;
    end else begin
      m_btn <= {m_btn[SYNC-2:0], bus.btn};
      m_sw  <= {m_sw[SYNC-2:0], bus.sw};
      m_rd  <= {m_rd[SYNC:0], bus.rd};
      if (m_btn[SYNC-1] == m_level) m_run <= 0;
      else if (m_run == DEB) begin m_level <= ~m_level; m_run <= 0; end
      else m_run <= m_run + 1;
      if (m_press) begin
        m_data   <= m_sw[SYNC-1];
        m_unread <= (m_rd_edge ? 0 : m_unread) + 1;
      end else if (m_rd_edge) begin
        m_unread <= 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_word(input logic [W-1:0] w);
    bus.sw = w; bus.btn = 1'b1; tick(8);
    bus.btn = 1'b0; tick(10);
  endtask

  task automatic read_word();
    bus.rd = 1'b1; tick(6);
    bus.rd = 1'b0; tick(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(2);
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== 10'b0) begin
      bad++; $display("FAIL reset_held: got %h/%b/%b want 00/0/0", bus.data, bus.valid, bus.overrun);
    end
    rst = 1'b0; tick(3);
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== 10'b0) begin
      bad++; $display("FAIL reset_idle: got %h/%b/%b want 00/0/0", bus.data, bus.valid, bus.overrun);
    end
  endtask

  task automatic test_capture();
    bus.sw = 8'hA5; bus.btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      total++;
      if (bus.valid !== (k >= 7)) begin
        bad++; $display("FAIL capture_valid k=%0d: got %b want %b", k, bus.valid, (k >= 7));
      end
      if (k >= 7) begin
        total++;
        if (bus.data !== 8'hA5 || bus.overrun !== 1'b0) begin
          bad++; $display("FAIL capture_word k=%0d: got %h/%b want a5/0", k, bus.data, bus.overrun);
        end
      end
    end
    bus.btn = 1'b0; tick(10);
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      read_word();
      press_word(w);
      total++;
      if ({bus.data, bus.valid, bus.overrun} !== {w, 1'b1, 1'b0}) begin
        bad++; $display("FAIL capture_rand %0d: got %h/%b/%b want %h/1/0", i, bus.data, bus.valid, bus.overrun, w);
      end
      last_word = w;
    end
  endtask

  task automatic test_read();
    logic [W-1:0] w2;
    bus.rd = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (bus.valid !== (k < 4) || bus.data !== last_word) begin
        bad++; $display("FAIL read_consume k=%0d: got %h/%b want %h/%b", k, bus.data, bus.valid, last_word, (k < 4));
      end
    end
    w2 = W'($urandom);
    press_word(w2);
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== {w2, 1'b1, 1'b0}) begin
      bad++; $display("FAIL read_held_once: got %h/%b/%b want %h/1/0", bus.data, bus.valid, bus.overrun, w2);
    end
    bus.rd = 1'b0; tick(4);
    total++;
    if (bus.valid !== 1'b1) begin
      bad++; $display("FAIL read_fall_ignored: got %b want 1", bus.valid);
    end
    last_word = w2;
  endtask

  task automatic test_bounce();
    logic [W-1:0] w;
    int rises;
    logic prev;
    read_word();
    w = W'($urandom);
    bus.sw = w;
    rises = 0;
    prev = bus.valid;
    for (int k = 0; k < 40; k++) begin
      if (k < 4)       bus.btn = (k % 2 == 0);
      else if (k < 16) bus.btn = 1'b1;
      else if (k < 20) bus.btn = (k % 2 == 1);
      else             bus.btn = 1'b0;
      if (k == 16) bus.sw = ~w;
      @(negedge clk);
      if (bus.valid && !prev) rises++;
      prev = bus.valid;
      total++;
      if (bus.valid !== (k + 1 >= 11)) begin
        bad++; $display("FAIL bounce_valid k=%0d: got %b want %b", k + 1, bus.valid, (k + 1 >= 11));
      end
      if (k + 1 >= 11) begin
        total++;
        if (bus.data !== w || bus.overrun !== 1'b0) begin
          bad++; $display("FAIL bounce_word k=%0d: got %h/%b want %h/0", k + 1, bus.data, bus.overrun, w);
        end
      end
    end
    total++;
    if (rises !== 1) begin
      bad++; $display("FAIL bounce_captures: got %0d want 1", rises);
    end
  endtask

  task automatic test_overrun();
    read_word();
    press_word(8'h11);
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== {8'h11, 1'b1, 1'b0}) begin
      bad++; $display("FAIL overrun_first: got %h/%b/%b want 11/1/0", bus.data, bus.valid, bus.overrun);
    end
    press_word(8'h22);
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== {8'h22, 1'b1, 1'b1}) begin
      bad++; $display("FAIL overrun_second: got %h/%b/%b want 22/1/1", bus.data, bus.valid, bus.overrun);
    end
    read_word();
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== {8'h22, 1'b0, 1'b0}) begin
      bad++; $display("FAIL overrun_clear: got %h/%b/%b want 22/0/0", bus.data, bus.valid, bus.overrun);
    end
  endtask

  task automatic test_coincide();
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = ~a;
    press_word(a);
    bus.sw = b; bus.btn = 1'b1;
    tick(3);
    bus.rd = 1'b1;
    tick(3);
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== {a, 1'b1, 1'b0}) begin
      bad++; $display("FAIL coincide_before: got %h/%b/%b want %h/1/0", bus.data, bus.valid, bus.overrun, a);
    end
    tick(1);
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== {b, 1'b1, 1'b0}) begin
      bad++; $display("FAIL coincide_swap: got %h/%b/%b want %h/1/0", bus.data, bus.valid, bus.overrun, b);
    end
    bus.btn = 1'b0; bus.rd = 1'b0; tick(10);
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== {b, 1'b1, 1'b0}) begin
      bad++; $display("FAIL coincide_after: got %h/%b/%b want %h/1/0", bus.data, bus.valid, bus.overrun, b);
    end
    read_word();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] c, d;
    c = W'($urandom);
    d = W'($urandom) | 8'h01;
    press_word(c);
    bus.sw = d; bus.btn = 1'b1;
    tick(4);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== 10'b0) begin
      bad++; $display("FAIL reset_async: got %h/%b/%b want 00/0/0", bus.data, bus.valid, bus.overrun);
    end
    tick(2);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      total++;
      if (bus.valid !== (k >= 7) || bus.data !== ((k >= 7) ? d : 8'h00)) begin
        bad++; $display("FAIL reset_recapture k=%0d: got %h/%b want %h/%b", k, bus.data, bus.valid, ((k >= 7) ? d : 8'h00), (k >= 7));
      end
    end
    bus.btn = 1'b0; tick(10);
    total++;
    if ({bus.data, bus.valid, bus.overrun} !== {d, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_single: got %h/%b/%b want %h/1/0", bus.data, bus.valid, bus.overrun, d);
    end
  endtask

  task automatic test_random();
    int bl = 0;
    int rl = 0;
    for (int n = 0; n < 1500; n++) begin
      if (bl == 0) begin bus.btn = 1'($urandom_range(0, 1)); bl = $urandom_range(1, 10); end
      if (rl == 0) begin bus.rd  = 1'($urandom_range(0, 1)); rl = $urandom_range(1, 6); end
      bl--; rl--;
      bus.sw = W'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      total++;
      if ({bus.data, bus.valid, bus.overrun} !== {m_data, (m_unread > 0), (m_unread > 1)}) begin
        bad++;
        $display("FAIL random n=%0d: got %h/%b/%b want %h/%b/%b", n, bus.data, bus.valid, bus.overrun,
                 m_data, (m_unread > 0), (m_unread > 1));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.sw = '0; bus.btn = 1'b0; bus.rd = 1'b0;
    last_word = '0;
    #2 rst = 1'b1;
    test_reset();
    test_capture();
    test_read();
    test_bounce();
    test_overrun();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
